elastic_pipeline: RTL and testbench

Parametrised STAGES-deep register pipeline with per-stage valid bits, a valid/ready handshake on both ends, bubble collapsing, synchronous flush and an occupancy count. It is the back-pressure-aware successor to the fixed-latency delay line. It sits between producer and consumer blocks whose throughput can stall, for example a math unit feeding a frame-buffer writer. Data order is preserved, and no beat is ever duplicated or dropped except by flush.

---
 rtl/elastic_pipeline.sv | 78 +++++++
 tb/tb_elastic_pipeline.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline.sv
// Elastic register pipeline with per-stage valid bits and valid/ready on both ends.
// Empty stages accept from upstream so bubbles collapse while the output stalls.
module elastic_pipeline #(
   parameter int STAGES     = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        flush_in,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic [$clog2(STAGES+1)-1:0] occupancy
);
   localparam int OCC_W = $clog2(STAGES+1);

   logic [STAGES-1:0]     valid_reg;
   logic [DATA_WIDTH-1:0] data_reg [STAGES];
   logic [STAGES-1:0]     ready;
   logic [OCC_W-1:0]      occ_reg;
   logic [OCC_W-1:0]      occ_next;
   logic                  in_xfer;
   logic                  out_xfer;

   // A stage may advance when the consumer takes a beat or any stage from it to
   // the output end is empty; this is the unrolled !valid[i] || ready[i+1] chain.
   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_ready
         assign ready[gi] = out_ready || !(&valid_reg[STAGES-1:gi]);
      end
   endgenerate

   assign in_ready  = ready[0] && !flush_in;
   assign out_valid = valid_reg[STAGES-1];
   assign out_data  = data_reg[STAGES-1];
   assign occupancy = occ_reg;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      occ_next = occ_reg;
      if (in_xfer && !out_xfer)
         occ_next = occ_reg + 1'b1;
      else if (!in_xfer && out_xfer)
         occ_next = occ_reg - 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_reg <= '0;
         occ_reg   <= '0;
         for (int i = 0; i < STAGES; i++)
            data_reg[i] <= '0;
      end else if (flush_in) begin
         // payload is left in place; only the valid bits matter after a flush
         valid_reg <= '0;
         occ_reg   <= '0;
      end else begin
         if (ready[0]) begin
            valid_reg[0] <= in_xfer;
            if (in_xfer)
               data_reg[0] <= in_data;
         end
         for (int i = 1; i < STAGES; i++) begin
            if (ready[i]) begin
               valid_reg[i] <= valid_reg[i-1];
               data_reg[i]  <= data_reg[i-1];
            end
         end
         occ_reg <= occ_next;
      end
   end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed checks of elastic_pipeline at STAGES=4/DATA_WIDTH=16 plus a
// scoreboarded run of a STAGES=1/DATA_WIDTH=1 instance.
module tb_elastic_pipeline;
   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic        rst_n_in;

   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [15:0] a_in_data, a_out_data;
   logic [2:0]  a_occ;

   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [0:0]  b_in_data, b_out_data;
   logic [0:0]  b_occ;

   int vectors     = 0;
   int miscompares = 0;
   int nxt;
   int accepted;
   int delivered;
   logic [0:0] pend;
   logic [0:0] sb_q[$];
   logic        bub_v [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [15:0] bub_d [5] = '{16'h0A01, 16'h0000, 16'h0000, 16'h0A02, 16'h0A03};
   logic [15:0] bub_exp [3] = '{16'h0A01, 16'h0A02, 16'h0A03};

   elastic_pipeline #(.STAGES(4), .DATA_WIDTH(16)) dut_a (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .flush_in  (a_flush),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .occupancy (a_occ)
   );

   elastic_pipeline #(.STAGES(1), .DATA_WIDTH(1)) dut_b (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .flush_in  (b_flush),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .occupancy (b_occ)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_in);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic log_a();
      if (a_in_valid && a_in_ready)
         $display("t=%0t in  %h", $time, a_in_data);
      if (a_out_valid && a_out_ready)
         $display("t=%0t out %h occ=%0d", $time, a_out_data, a_occ);
   endtask

   initial begin
      rst_n_in   = 1'b0;
      a_flush    = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
      b_flush    = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      #2;
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_data",  a_out_data,  0);
      check("rst_occ",       a_occ,       0);
      check("rst_in_ready",  a_in_ready,  1);
      #10 rst_n_in = 1'b1;

      // streaming 0x0001..0x0010 with the consumer always ready
      for (int c = 0; c <= 20; c++) begin
         next_cycle();
         a_out_ready = 1'b1;
         a_in_valid  = (c < 16);
         a_in_data   = 16'(c + 1);
         settle();
         check("stream_in_ready", a_in_ready, 1);
         check("stream_out_valid", a_out_valid, (c >= 4 && c < 20));
         if (c >= 4 && c < 20)
            check("stream_out_data", a_out_data, c - 3);
         check("stream_occ", a_occ, ((c < 16) ? c : 16) - ((c > 4) ? c - 4 : 0));
         log_a();
      end

      // stall/fill: six beats offered against a stalled consumer
      nxt = 1;
      for (int c = 0; c < 6; c++) begin
         next_cycle();
         a_out_ready = 1'b0;
         a_in_valid  = 1'b1;
         a_in_data   = 16'(nxt);
         settle();
         check("fill_in_ready", a_in_ready, (c < 4));
         log_a();
         if (a_in_valid && a_in_ready) nxt++;
      end
      check("fill_accepted", nxt - 1, 4);
      for (int r = 0; r <= 6; r++) begin
         next_cycle();
         a_out_ready = 1'b1;
         a_in_valid  = (nxt <= 6);
         a_in_data   = 16'(nxt);
         settle();
         if (r == 0) check("fill_occ", a_occ, 4);
         check("drain_valid", a_out_valid, (r < 6));
         if (r < 6) check("drain_data", a_out_data, r + 1);
         log_a();
         if (a_in_valid && a_in_ready) nxt++;
      end
      check("drain_all_accepted", nxt, 7);

      // bubble collapse: gapped input, output stalled throughout
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         a_out_ready = 1'b0;
         a_in_valid  = (c < 5) ? bub_v[c] : 1'b0;
         a_in_data   = (c < 5) ? bub_d[c] : 16'h0;
         settle();
         check("bubble_in_ready", a_in_ready, 1);
         log_a();
      end
      check("bubble_occ",       a_occ,       3);
      check("bubble_out_valid", a_out_valid, 1);
      check("bubble_head",      a_out_data,  16'h0A01);
      for (int r = 0; r < 4; r++) begin
         next_cycle();
         a_out_ready = 1'b1;
         a_in_valid  = 1'b0;
         settle();
         check("bubble_drain_valid", a_out_valid, (r < 3));
         if (r < 3) check("bubble_drain_data", a_out_data, bub_exp[r]);
         log_a();
      end

      // flush with three beats in flight
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         a_out_ready = 1'b0;
         a_in_valid  = (c < 3);
         a_in_data   = 16'h0B01 + 16'(c);
         settle();
         log_a();
      end
      check("flush_pre_occ", a_occ, 3);
      next_cycle();
      a_flush = 1'b1; a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 16'h0B04;
      settle();
      check("flush_in_ready",  a_in_ready,  0);
      check("flush_out_valid", a_out_valid, 1);
      check("flush_out_data",  a_out_data,  16'h0B01);
      log_a();
      next_cycle();
      a_flush = 1'b0; a_out_ready = 1'b0; a_in_valid = 1'b0;
      settle();
      check("post_flush_valid", a_out_valid, 0);
      check("post_flush_occ",   a_occ,       0);
      check("post_flush_ready", a_in_ready,  1);

      // asynchronous reset with the pipeline full
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         a_out_ready = 1'b0;
         a_in_valid  = (c < 4);
         a_in_data   = 16'h0C01 + 16'(c);
         settle();
         log_a();
      end
      check("prereset_occ",   a_occ,      4);
      check("prereset_ready", a_in_ready, 0);
      #2 rst_n_in = 1'b0;
      #1;
      check("async_rst_valid", a_out_valid, 0);
      check("async_rst_data",  a_out_data,  0);
      check("async_rst_occ",   a_occ,       0);
      check("async_rst_ready", a_in_ready,  1);
      #2 rst_n_in = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         next_cycle();
         a_out_ready = 1'b1;
         a_in_valid  = (c == 0);
         a_in_data   = 16'hABCD;
         settle();
         check("after_rst_valid", a_out_valid, (c == 4));
         if (c == 4) check("after_rst_data", a_out_data, 16'hABCD);
         log_a();
      end
      a_in_valid = 1'b0;

      // STAGES=1, DATA_WIDTH=1 with alternating consumer against a scoreboard
      accepted  = 0;
      delivered = 0;
      pend      = 1'($urandom_range(0, 1));
      for (int c = 0; c < 400 && delivered < 100; c++) begin
         next_cycle();
         b_in_valid  = (accepted < 100);
         b_in_data   = pend;
         b_out_ready = (c % 2 == 0);
         settle();
         check("d1_in_ready",  b_in_ready,  (!b_out_valid || b_out_ready));
         check("d1_occ",       b_occ,       sb_q.size());
         check("d1_out_valid", b_out_valid, (sb_q.size() != 0));
         if (b_out_valid && b_out_ready) begin
            if (sb_q.size() != 0)
               check("d1_order", b_out_data, sb_q.pop_front());
            else
               check("d1_spurious_out", b_out_valid, 0);
            delivered++;
            $display("t=%0t d1 out %0d (#%0d)", $time, b_out_data, delivered);
         end
         if (b_in_valid && b_in_ready) begin
            sb_q.push_back(b_in_data);
            accepted++;
            pend = 1'($urandom_range(0, 1));
         end
      end
      b_in_valid = 1'b0;
      check("d1_delivered", delivered, 100);
      check("d1_leftover",  sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
